// File: rtl/regfile_write_demux.sv
// ----------------------------------------------------------------------------
// regfile_write_demux
//
// Write-side demux between the WB stage and the register file. Accepted
// writes go into a small in-order staging buffer. The head entry is issued
// as a registered one-hot write enable plus data whenever the register file
// can take it. Writes that target the hard-wired zero register are accepted
// and then dropped.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   WB stage offers a write this cycle
//   in_ready   buffer can accept; transfer = in_valid & in_ready
//   in_addr    destination register index
//   in_data    data to write
//   out_ready  register file can take a write this cycle
//   we_onehot  registered one-hot write enable, single-cycle pulse per write
//   wdata      registered write data paired with we_onehot
//   pending    bit k set = a buffered write to reg k has not issued yet
//   count      number of buffered entries
// ----------------------------------------------------------------------------
module regfile_write_demux #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31,
    parameter int DEPTH    = 2,
    localparam int NREG    = 2**ADDR_W,
    localparam int CNT_W   = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic [NREG-1:0]   we_onehot,
    output logic [DATA_W-1:0] wdata,
    output logic [NREG-1:0]   pending,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    // Pointer arithmetic modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input int               n);
        int s;
        s = int'(p) + n;
        while (s >= DEPTH) s = s - DEPTH;
        return PTR_W'(s);
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [NREG-1:0]     we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [ADDR_W-1:0]   mem_addr_q [DEPTH];
    logic [DATA_W-1:0]   mem_data_q [DEPTH];

    logic                push;
    logic                pop;

    // ------------------------------------------------------------------
    // Next-state and handshake logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        we_d     = '0;
        wdata_d  = wdata_q;

        // No pass-through when full, even if a pop happens this cycle.
        in_ready = (state_q != FULL) & ~reset;
        pop      = (state_q != EMPTY) & out_ready;
        // Zero-register writes complete the handshake but never enter
        // the buffer.
        push     = in_valid & in_ready & (in_addr != ADDR_W'(ZERO_REG));

        if (pop) begin
            we_d    = NREG'(1) << mem_addr_q[head_q];
            wdata_d = mem_data_q[head_q];
            head_d  = ptr_add(head_q, 1);
        end
        if (push) begin
            tail_d = ptr_add(tail_q, 1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            EMPTY: begin
                if (push) state_d = (DEPTH == 1) ? FULL : PARTIAL;
            end
            PARTIAL: begin
                if (push && !pop && count_q == CNT_W'(DEPTH-1)) state_d = FULL;
                else if (pop && !push && count_q == CNT_W'(1))  state_d = EMPTY;
            end
            FULL: begin
                if (pop) state_d = (DEPTH == 1) ? EMPTY : PARTIAL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // Buffer storage: contents are qualified by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[tail_q] <= in_addr;
            mem_data_q[tail_q] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // pending: decoded addresses of every live entry. The entry on
    // we_onehot has already left the buffer, so it is excluded.
    // ------------------------------------------------------------------
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                pending[mem_addr_q[ptr_add(head_q, i)]] = 1'b1;
            end
        end
    end

    assign we_onehot = we_q;
    assign wdata     = wdata_q;
    assign count     = count_q;

endmodule

// File: tb/tb_regfile_write_demux.sv
module tb_regfile_write_demux;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam int ZERO   = 31;
    localparam int DEPTH  = 2;
    localparam int NREG   = 32;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;
    logic [NREG-1:0]   we_onehot;
    logic [DATA_W-1:0] wdata;
    logic [NREG-1:0]   pending;
    logic [1:0]        count;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    ent_t mq[$];   // model of buffered, not yet issued writes
    ent_t sb[$];   // issued writes whose pulse is expected next

    regfile_write_demux #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(ZERO), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .out_ready(out_ready),
        .we_onehot(we_onehot), .wdata(wdata), .pending(pending), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: update buffer queue on each edge.
    always @(posedge clk) begin
        bit   p_push, p_pop;
        ent_t e;
        if (reset) begin
            mq.delete();
            sb.delete();
        end else begin
            p_push = in_valid && (mq.size() < DEPTH) && (in_addr != ZERO);
            p_pop  = (mq.size() > 0) && out_ready;
            if (p_pop) begin
                e = mq.pop_front();
                sb.push_back(e);
            end
            if (p_push) begin
                e.a = in_addr;
                e.d = in_data;
                mq.push_back(e);
            end
        end
    end

    // Scoreboard / status checker, sampled on the falling edge.
    always @(negedge clk) begin
        logic [NREG-1:0] ep;
        ent_t e;
        if (chk_en) begin
            ep = '0;
            foreach (mq[i]) ep[mq[i].a] = 1'b1;
            chk("sb_count", 64'(count), 64'(mq.size()));
            chk("sb_pending", 64'(pending), 64'(ep));
            chk("sb_in_ready", 64'(in_ready), 64'((mq.size() < DEPTH) && !reset));
            if (we_onehot != '0) begin
                if (sb.size() == 0) begin
                    chk("sb_spurious_pulse", 64'(we_onehot), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("sb_we", 64'(we_onehot), 64'(NREG'(1) << e.a));
                    chk("sb_wdata", wdata, e.d);
                end
            end
            chk("sb_missing_pulse", 64'(sb.size()), 64'(0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; out_ready = 1'b0;

        // Reset state
        cyc(1);
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_we", 64'(we_onehot), 64'(0));
        chk("rst_wdata", wdata, 64'(0));
        chk("rst_pending", 64'(pending), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk_en = 1'b1;
        reset = 1'b0;
        cyc(1);

        // 1: single write, two-cycle latency, one-cycle pulse
        out_ready = 1'b1;
        offer(5'd3, 64'hDEAD);
        cyc(1);
        in_valid = 1'b0;
        chk("t1_count", 64'(count), 64'(1));
        chk("t1_we_early", 64'(we_onehot), 64'(0));
        cyc(1);
        chk("t1_we", 64'(we_onehot), 64'h8);
        chk("t1_wdata", wdata, 64'hDEAD);
        cyc(1);
        chk("t1_we_off", 64'(we_onehot), 64'(0));
        chk("t1_wdata_hold", wdata, 64'hDEAD);

        // 2: zero-register write is swallowed
        offer(5'd31, 64'h1234);
        chk("t2_ready", 64'(in_ready), 64'(1));
        cyc(1);
        in_valid = 1'b0;
        chk("t2_count", 64'(count), 64'(0));
        chk("t2_pending", 64'(pending), 64'(0));
        chk("t2_ready_after", 64'(in_ready), 64'(1));
        cyc(1);
        chk("t2_we", 64'(we_onehot), 64'(0));

        // 3: fill while stalled, then drain in order
        out_ready = 1'b0;
        offer(5'd5, 64'h5);
        cyc(1);
        offer(5'd6, 64'h6);
        cyc(1);
        offer(5'd7, 64'h7);
        cyc(2);
        chk("t3_count", 64'(count), 64'(2));
        chk("t3_ready", 64'(in_ready), 64'(0));
        chk("t3_pending", 64'(pending), 64'h60);
        out_ready = 1'b1;
        cyc(1);
        chk("t3_we5", 64'(we_onehot), 64'h20);
        chk("t3_count1", 64'(count), 64'(1));
        cyc(1);
        in_valid = 1'b0;
        chk("t3_we6", 64'(we_onehot), 64'h40);
        chk("t3_count2", 64'(count), 64'(1));
        chk("t3_pending7", 64'(pending), 64'h80);
        cyc(1);
        chk("t3_we7", 64'(we_onehot), 64'h80);
        chk("t3_count3", 64'(count), 64'(0));

        // 4: simultaneous push and pop at count=1
        out_ready = 1'b0;
        offer(5'd9, 64'h9);
        cyc(1);
        chk("t4_count", 64'(count), 64'(1));
        offer(5'd10, 64'hA);
        out_ready = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        chk("t4_count_hold", 64'(count), 64'(1));
        chk("t4_we9", 64'(we_onehot), 64'h200);
        cyc(1);
        chk("t4_we10", 64'(we_onehot), 64'h400);
        chk("t4_count0", 64'(count), 64'(0));

        // 5: two writes to the same register, both issue in order
        out_ready = 1'b0;
        offer(5'd2, 64'hAAAA_0001);
        cyc(1);
        offer(5'd2, 64'hBBBB_0002);
        cyc(1);
        in_valid = 1'b0;
        chk("t5_pending", 64'(pending), 64'h4);
        out_ready = 1'b1;
        cyc(1);
        chk("t5_weA", 64'(we_onehot), 64'h4);
        chk("t5_dataA", wdata, 64'hAAAA_0001);
        cyc(1);
        chk("t5_weB", 64'(we_onehot), 64'h4);
        chk("t5_dataB", wdata, 64'hBBBB_0002);
        cyc(1);
        chk("t5_we_off", 64'(we_onehot), 64'(0));

        // 6: reset while full drops buffered writes
        out_ready = 1'b0;
        offer(5'd12, 64'hC);
        cyc(1);
        offer(5'd13, 64'hD);
        cyc(1);
        in_valid = 1'b0;
        chk("t6_count_full", 64'(count), 64'(2));
        reset = 1'b1;
        out_ready = 1'b1;
        cyc(1);
        chk("t6_count", 64'(count), 64'(0));
        chk("t6_pending", 64'(pending), 64'(0));
        chk("t6_we", 64'(we_onehot), 64'(0));
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("t6_no_pulse", 64'(we_onehot), 64'(0));
        end

        // Random traffic, checked by the scoreboard
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_addr   = (($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31)));
            in_data   = {$urandom, $urandom};
            cyc(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc(4);
        chk("drain_count", 64'(count), 64'(0));
        chk("drain_model", 64'(mq.size() + sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
